// File: rtl/pcpu_boot_mem.sv
`default_nettype none
// ============================================================================
// Module  : pcpu_boot_mem
// Brief   : Instruction/data memory responder and boot sequencer for the
//           16-bit pipeline CPU. A host streams a program and data image in,
//           the CPU is enabled and started, then fetches/loads/stores are
//           served until a HALT opcode is fetched.
// Revision: 1.0 - initial release
// ============================================================================
module pcpu_boot_mem #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int START_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              running,
  output logic              halted
);

  localparam int              c_DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W:0] c_PTR_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [3:0]      c_CNT_ONE   = 4'd1;
  localparam logic [3:0]      c_START_LEN = 4'(START_CYCLES);
  localparam logic [4:0]      c_HALT_OP   = 5'b00001;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_LOAD  = 2'd1;
  localparam logic [1:0] c_START = 2'd2;
  localparam logic [1:0] c_RUN   = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W:0]   r_ptr;
  logic [3:0]        r_start_cnt;
  logic              r_ld_ready;
  logic              r_cpu_enable;
  logic              r_cpu_start;
  logic              r_running;
  logic              r_halted;

  logic [DATA_W-1:0] r_imem [c_DEPTH];
  logic [DATA_W-1:0] r_dmem [c_DEPTH];

  logic              w_xfer;
  logic              w_ptr_full;
  logic              w_term;
  logic              w_run;
  logic              w_halt_op;
  logic [DATA_W-1:0] w_ifetch;

  // ld_ready is only ever high in IDLE/LOAD, so it alone qualifies a transfer
  assign w_xfer     = ld_valid & r_ld_ready;
  assign w_ptr_full = &r_ptr;
  assign w_term     = w_xfer & (ld_last | w_ptr_full);
  assign w_run      = (r_state == c_RUN);
  assign w_ifetch   = r_imem[i_addr];
  assign w_halt_op  = (w_ifetch[DATA_W-1 -: 5] == c_HALT_OP);

  assign i_datain   = w_ifetch;
  assign d_datain   = r_dmem[d_addr];
  assign ld_ready   = r_ld_ready;
  assign cpu_enable = r_cpu_enable;
  assign cpu_start  = r_cpu_start;
  assign running    = r_running;
  assign halted     = r_halted;

  // Boot sequencer: load image, hold start for START_CYCLES, then run
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= c_IDLE;
      r_ptr        <= '0;
      r_start_cnt  <= '0;
      r_ld_ready   <= 1'b0;
      r_cpu_enable <= 1'b0;
      r_cpu_start  <= 1'b0;
      r_running    <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE, c_LOAD: begin
          r_ld_ready <= ~w_term;
          if (w_xfer) begin
            // Pointer saturates at all-ones; that transfer terminates the load
            if (!w_ptr_full) begin
              r_ptr <= r_ptr + c_PTR_ONE;
            end
            if (w_term) begin
              r_state      <= c_START;
              r_cpu_enable <= 1'b1;
              r_cpu_start  <= 1'b1;
              r_start_cnt  <= c_CNT_ONE;
            end else begin
              r_state <= c_LOAD;
            end
          end
        end
        c_START: begin
          if (r_start_cnt == c_START_LEN) begin
            r_state     <= c_RUN;
            r_cpu_start <= 1'b0;
            r_running   <= 1'b1;
          end else begin
            r_start_cnt <= r_start_cnt + c_CNT_ONE;
          end
        end
        c_RUN: begin
          // Sticky halt flag; the CPU is left enabled
          if (w_halt_op) begin
            r_halted <= 1'b1;
          end
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  // Instruction memory is written only from the load port (pointer MSB clear)
  always_ff @(posedge clock) begin
    if (w_xfer && !r_ptr[ADDR_W]) begin
      r_imem[r_ptr[ADDR_W-1:0]] <= ld_data;
    end
  end

  // Data memory: load port while booting (pointer MSB set), CPU stores in RUN
  always_ff @(posedge clock) begin
    if (w_xfer && r_ptr[ADDR_W]) begin
      r_dmem[r_ptr[ADDR_W-1:0]] <= ld_data;
    end else if (w_run && d_we) begin
      r_dmem[d_addr] <= d_dataout;
    end
  end

endmodule
`default_nettype wire

// File: doc/pcpu_boot_mem.md
Name: pcpu_boot_mem

Overview:
- Memory-side responder for the 16-bit pipeline CPU's instruction and data buses: instruction memory, data memory, and boot sequencer in one block.
- A host streams a program and initial data image through a valid/ready load port while the CPU is held disabled. The block then enables the CPU, pulses its start, and serves fetches, loads and stores until the CPU fetches HALT.
- Replaces bench-driven instruction/data stimulus in system-level simulation.

Parameters:
ADDR_W, 8, width of i_addr/d_addr; each memory is 2**ADDR_W words
DATA_W, 16, instruction and data word width
START_CYCLES, 1, number of cycles cpu_start is held high (range 1..15)

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state except memory contents
ld_valid  input  1  host load word valid
ld_ready  output  1  block accepts a load word this cycle
ld_data  input  DATA_W  load word
ld_last  input  1  marks the final load word
i_addr  input  ADDR_W  CPU instruction fetch address
i_datain  output  DATA_W  instruction word to CPU
d_addr  input  ADDR_W  CPU data address
d_dataout  input  DATA_W  CPU store data
d_we  input  1  CPU store strobe
d_datain  output  DATA_W  load data to CPU
cpu_enable  output  1  drives CPU enable
cpu_start  output  1  drives CPU start
running  output  1  high in RUN state
halted  output  1  sticky; HALT opcode fetched

Behaviour:
- FSM states: IDLE, LOAD, START, RUN. Reset forces IDLE.
- Reset values:
  - ld_ready=0, cpu_enable=0, cpu_start=0, running=0, halted=0.
  - Load pointer=0 and start counter=0.
  - Memory contents are preserved.
- Registered outputs: ld_ready becomes 1 on the first rising edge after reset deasserts.
- Load pointer: ADDR_W+1 bits.
  - Pointer values 0..2**ADDR_W-1 address instruction memory (pointer MSB=0).
  - Pointer values 2**ADDR_W..2**(ADDR_W+1)-1 address data memory (pointer MSB=1).
  - A host loads instructions first, then data words.
- Transfer: occurs on a rising edge with ld_valid=1 and ld_ready=1. ld_data is written at the pointer, and the pointer increments.
  - IDLE goes to LOAD on the first transfer.
- ld_ready stays 1 in IDLE and LOAD. There is no back-pressure during loading.
- Load termination: on a transfer with ld_last=1, or on a transfer at pointer = all-ones (memory full), the FSM goes to START.
  - On that edge ld_ready falls to 0 and cpu_enable rises to 1.
  - A full-memory transfer with ld_last=0 terminates identically. The pointer never wraps.
- START:
  - cpu_start=1 for exactly START_CYCLES cycles, counted by the start counter.
  - cpu_enable stays 1.
  - Then RUN, with cpu_start=0 and running=1.
- RUN:
  - ld_ready=0. ld_valid is ignored and no memory is written from the load port.
  - i_datain = imem[i_addr] and d_datain = dmem[d_addr], both combinational asynchronous reads. There are zero cycles of latency; the CPU samples the data at its next edge.
  - Stores: a rising edge with d_we=1 in RUN writes d_dataout to dmem[d_addr]. A read of the same address in the same cycle returns the old value; the new value is visible after the edge.
  - d_we is ignored outside RUN.
- Halt detection:
  - In RUN, a rising edge where i_datain[DATA_W-1:DATA_W-5]=5'b00001 sets halted=1.
  - halted is sticky until reset. cpu_enable remains 1.
  - The block does not stop the CPU itself.
- Outside RUN, i_datain and d_datain still reflect the memory at the presented addresses (combinational reads are always active).
- Reset mid-load or mid-run: the FSM returns to IDLE at once (asynchronously) and cpu_enable drops. Partially loaded words remain in memory, but the pointer restarts at 0.
- Simultaneous events:
  - ld_valid together with reset high: no transfer.
  - ld_last on the full-memory word: a single termination.
- Width rules: the pointer increment is unsigned, ADDR_W+1 bits. Opcode compare uses the top 5 bits only.

Test Plan:
- Load 3 words (LDIH gr1: 16'h81CB, LDIH gr2: 16'h82B8, HALT: 16'h0800) with ld_last on the 3rd.
  - Required: imem[0..2] hold these values.
  - ld_ready falls on the 3rd accept edge; cpu_enable rises on the same edge.
  - cpu_start is high for exactly 1 cycle, then running=1.
- With START_CYCLES=3:
  - cpu_start is high for exactly 3 consecutive cycles.
- In RUN, drive i_addr=2.
  - Required: i_datain=16'h0800 combinationally, and halted=1 after the next rising edge.
  - halted stays 1 while i_addr changes.
- Load 256 instruction words plus 2 data words (16'h00AB, 16'h3C00, last on the 2nd word).
  - Required: d_addr=1 → d_datain=16'h3C00.
  - In RUN, d_we=1, d_addr=1, d_dataout=16'h1234: the same cycle reads 16'h3C00, and the next cycle reads 16'h1234.
- Stream 512 words with ld_last=0 (ADDR_W=8).
  - Required: transition to START on the 512th accept and no wrap (imem[0] unchanged).
  - Further ld_valid is ignored; ld_ready=0.
- Assert reset for 3 ns mid-load (after 2 words), between clock edges.
  - Required: ld_ready=0 and cpu_enable=0 immediately.
  - After release, reload 1 word with last: it writes imem[0], and START follows.
- d_we=1 during IDLE.
  - Required: dmem unchanged.
